// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built from two half_adder cells, an OR gate and a carry flop.
// Optional carry-in port enabled by defining SERIAL_ADDER_CIN_EN.

module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

// Handshake: start is a request that is accepted only while idle (busy=0, done=0);
// the result is valid for exactly the one cycle in which done=1, and is held afterwards.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             Cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic [1:0]       fsm_state
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             cin_init;

    logic             p_sum;
    logic             p_carry;
    logic             s_bit;
    logic             s_carry;
    logic             cnext;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_init = Cin;
`else
    assign cin_init = 1'b0;
`endif

    // Full-adder slice: two half adders with their carries ORed.
    half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]), .sum(p_sum), .carry(p_carry));
    half_adder u_ha1 (.a(p_sum),  .b(c_q),    .sum(s_bit), .carry(s_carry));
    assign cnext = p_carry | s_carry;

    assign res_next = {s_bit, res_q[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            cnt   <= '0;
            Sum   <= '0;
            Carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= A;
                        b_q <= B;
                        c_q <= cin_init;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_next;
                    c_q   <= cnext;
                    cnt   <= cnt + 1'b1;
                    // The last bit's sum and carry are taken straight from the slice.
                    if (last_bit) begin
                        Sum   <= res_next;
                        Carry <= cnext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), covering reset, carries,
// busy lockout, mid-shift abort and, when SERIAL_ADDER_CIN_EN is defined, carry-in.

module tb_serial_adder;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;
    logic [1:0]   fsm_state;

    int n_checks;
    int n_fail;
    logic [W:0] exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (a),
        .B         (b),
`ifdef SERIAL_ADDER_CIN_EN
        .Cin       (cin),
`endif
        .busy      (busy),
        .done      (done),
        .Sum       (sum),
        .Carry     (carry),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done while counting busy cycles; called in the cycle after the accept edge.
    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag);
        logic [W:0] e;
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, sum, e[W-1:0]);
            check({tag, "_carry"}, carry, e[W]);
        end
    endtask

    // Driver: one addition; operands and Cin are scrambled right after acceptance.
    task automatic add_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv);
        int bc;
        logic cuse;
`ifdef SERIAL_ADDER_CIN_EN
        cuse = cv;
`else
        cuse = 1'b0;
`endif
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        exp_q.push_back({1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cuse});
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; cin = ~cv;
        wait_done(bc);
        check({tag, "_busy_cycles"}, bc, W);
        check_result(tag);
        @(negedge clk);
        check({tag, "_idle_after"}, fsm_state, 0);
    endtask

    initial begin
        int bc;
        int done_seen;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b1;

        // Reset held 2 cycles with start asserted
        repeat (2) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_carry", carry, 0);
        check("rst_state", fsm_state, 0);

        add_op("basic", 8'h0F, 8'h01, 1'b0);
        add_op("ff_01", 8'hFF, 8'h01, 1'b0);
        add_op("ff_ff", 8'hFF, 8'hFF, 1'b0);
        add_op("80_80", 8'h80, 8'h80, 1'b0);
        add_op("55_aa", 8'h55, 8'hAA, 1'b0);

        // Busy lockout: start held high through SHIFT and DONE with new operands
        @(negedge clk);
        a = 8'h12; b = 8'h34; start = 1'b1; cin = 1'b0;
        exp_q.push_back(9'h046);
        @(negedge clk);
        a = 8'hFF; b = 8'hFF;
        check("lock_state_shift", fsm_state, 1);
        wait_done(bc);
        check("lock_busy_cycles", bc, W);
        check_result("lock1");
        @(negedge clk);
        check("lock_idle", fsm_state, 0);
        exp_q.push_back(9'h1FE);
        @(negedge clk);
        start = 1'b0;
        check("lock_reaccept", busy, 1);
        check("lock_sum_held", sum, 8'h46);
        wait_done(bc);
        check("lock2_busy_cycles", bc, W);
        check_result("lock2");

        // Abort: reset during the 4th SHIFT cycle
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sum", sum, 8'h00);
        check("abort_carry", carry, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("abort_no_done", done_seen, 0);
        add_op("after_abort", 8'h01, 8'h02, 1'b0);

`ifdef SERIAL_ADDER_CIN_EN
        add_op("cin_ff_00", 8'hFF, 8'h00, 1'b1);
        add_op("cin_10_20", 8'h10, 8'h20, 1'b1);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
